// File: rtl/mby_gmm_pkg.sv
// Shared EGR/tag-ring types: ring slot layout, buffered tag layout and field widths.
package mby_gmm_pkg;

  localparam int EGR_ID_W      = 4;
  localparam int PORT_W        = 5;
  localparam int TC_W          = 3;
  localparam int PTR_W         = 12;
  localparam int LEN_W         = 10;
  localparam int EGR_TAG_DEPTH = 8;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [TC_W-1:0]   tc;
    logic [PTR_W-1:0]  ptr;
    logic [LEN_W-1:0]  len;
  } egr_tag_t;

  typedef struct packed {
    logic                valid;
    logic [EGR_ID_W-1:0] dest_egr;
    logic [PORT_W-1:0]   port;
    logic [TC_W-1:0]     tc;
    logic [PTR_W-1:0]    ptr;
    logic [LEN_W-1:0]    len;
  } mby_tag_ring_t;

  function automatic egr_tag_t ring_to_tag(input mby_tag_ring_t s);
    egr_tag_t t;
    t.port = s.port;
    t.tc   = s.tc;
    t.ptr  = s.ptr;
    t.len  = s.len;
    return t;
  endfunction

endpackage

// File: rtl/mby_egr_tag_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module mby_egr_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          push_ok,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  // Head is zeroed when empty so the output reads 0 out of reset.
  assign rdata     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/egr_tagring_rx.sv
// EGR tag ring stop: capture tags addressed to this EGR, buffer them, hand to scheduler.
module egr_tagring_rx
  import mby_gmm_pkg::*;
#(
  parameter int EGR_ID    = 0,
  parameter int DEPTH     = EGR_TAG_DEPTH,
  parameter int AFULL_THR = 6,
  parameter int CNT_W     = 16,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          cclk,
  input  logic          rst,
  input  mby_tag_ring_t mby_tag_ring,
  output logic          tag_valid,
  input  logic          tag_ready,
  output egr_tag_t      tag_data,
  output logic          tag_afull,
  output logic [CW-1:0] tag_count,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic          drop_clr
);

  localparam int STAGES = 0;

  logic [STAGES:0] vld_pipe;
  egr_tag_t        cap_tag;
  logic            match;
  logic            push_ok, fifo_full, fifo_empty, drop;
  logic [CW-1:0]   cnt_nxt;
  logic [$bits(egr_tag_t)-1:0] fifo_rdata;

  assign match = mby_tag_ring.valid && (mby_tag_ring.dest_egr == EGR_ID_W'(EGR_ID));

  // Capture stage: the ring never stalls, so this register loads every cycle.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      cap_tag  <= '0;
    end else begin
      vld_pipe[0] <= match;
      cap_tag     <= ring_to_tag(mby_tag_ring);
    end
  end

  mby_egr_tag_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(egr_tag_t))
  ) u_fifo (
    .clk       (cclk),
    .rst       (rst),
    .push      (vld_pipe[STAGES]),
    .wdata     (cap_tag),
    .pop       (tag_ready),
    .rdata     (fifo_rdata),
    .push_ok   (push_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (tag_count),
    .count_nxt (cnt_nxt)
  );

  assign tag_valid = !fifo_empty;
  assign tag_data  = egr_tag_t'(fifo_rdata);
  assign drop      = vld_pipe[STAGES] && !push_ok;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      tag_afull <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      tag_afull <= (cnt_nxt >= CW'(AFULL_THR));
      if (drop_clr)
        drop_cnt <= '0;
      else if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
